// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only). Backpressure: n/a.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response channel between fetch unit and memory.
// Latency: none (wires only). Backpressure: request held until imem_ready.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next fetch address selection: sequential PC+4 or redirect target, plus alignment check.
// Latency: combinational. Backpressure: none.
module pc_next
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_src_i,
    input  logic [XLEN-1:0] pc_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misalign_o
);

    // Natural 32-bit truncation gives the required wrap from FFFF_FFFC to 0.
    assign pc_plus4_o = pc_i + 32'd4;
    assign next_pc_o  = pc_src_i ? pc_target_i : pc_plus4_o;
    assign misalign_o = pc_src_i & ~is_word_aligned(pc_target_i);

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher: request, wait for data, hold until consumed.
// Latency: rvalid in cycle k -> instr_valid in k+1; consume in m -> imem_req in m+1. Backpressure: stall holds the instruction.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            stall,
    fetch_unit_if.master    imem,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    output logic            misaligned
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            valid_q;
    logic            req_q;
    logic            misaligned_q;

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_plus4;
    logic            target_misaligned;
    logic            consume;

    pc_next u_pc_next (
        .pc_i        (pc_q),
        .pc_src_i    (PCSrc),
        .pc_target_i (PCTarget),
        .next_pc_o   (next_pc),
        .pc_plus4_o  (pc_plus4),
        .misalign_o  (target_misaligned)
    );

    assign consume = valid_q & ~stall;

    // req_q comes up one clock after reset release, so nothing is requested while in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
            req_q        <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_q && imem.imem_ready) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        instr_q <= imem.imem_rdata;
                        pc_q    <= fetch_pc_q;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        valid_q <= 1'b0;
                        if (target_misaligned) begin
                            misaligned_q <= 1'b1;
                            state_q      <= TRAP;
                        end else begin
                            fetch_pc_q <= next_pc;
                            req_q      <= 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                end
                TRAP: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = fetch_pc_q;

    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign instr_valid = valid_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized transaction run.
// Memory contents come from an address hash; next-address expectations from the redirect rule.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        stall;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .stall       (stall),
        .imem        (imem_bus),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ (a * 32'h0001_0001);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        PCSrc = 1'b0;
        PCTarget = 32'h0;
        stall = 1'b0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Memory responder: waits for a request, accepts after rdy_dly cycles, answers rv_dly cycles later.
    task automatic serve(input int rdy_dly, input int rv_dly,
                         output logic [31:0] got_addr, output bit timed_out, output int bad);
        bad = 0;
        timed_out = 1'b1;
        got_addr = 32'hxxxx_xxxx;
        for (int i = 0; i < 20; i++) begin
            if (imem_bus.imem_req === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            step();
        end
        if (timed_out) return;
        got_addr = imem_bus.imem_addr;
        for (int i = 0; i < rdy_dly; i++) begin
            imem_bus.imem_ready = 1'b0;
            imem_bus.imem_rvalid = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom;
            step();
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== got_addr || instr_valid !== 1'b0) bad++;
        end
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rvalid = 1'b0;
        step();
        imem_bus.imem_ready = 1'b0;
        for (int i = 0; i <= rv_dly; i++) begin
            if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0) bad++;
            if (i == rv_dly) begin
                imem_bus.imem_rvalid = 1'b1;
                imem_bus.imem_rdata = mem_word(got_addr);
            end
            step();
        end
        imem_bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        PCSrc = 1'b0;
        PCTarget = 32'h0;
        stall = 1'b0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        step();
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
        checks++; if (PC !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", PC, RST_PC); end
        checks++; if (Instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", Instr, NOP); end
        checks++; if (PCPlus4 !== RST_PC + 32'd4) begin errors++; $display("FAIL reset_pcplus4: got %h want %h", PCPlus4, RST_PC + 32'd4); end
        step();
        reset = 1'b0;
        step();
        checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL release_req: got %b want 1", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== RST_PC) begin errors++; $display("FAIL release_addr: got %h want %h", imem_bus.imem_addr, RST_PC); end
    endtask

    task automatic test_first_fetch();
        logic [31:0] a;
        bit to;
        int bad;
        do_reset();
        serve(0, 0, a, to, bad);
        checks++; if (to) begin errors++; $display("FAIL first_timeout: no request seen, want imem_req=1"); end
        checks++; if (a !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 00000000", a); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL first_protocol: got %0d violations want 0", bad); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", instr_valid); end
        checks++; if (Instr !== 32'h0050_0093) begin errors++; $display("FAIL first_instr: got %h want 00500093", Instr); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL first_pc: got %h want 00000000", PC); end
        checks++; if (PCPlus4 !== 32'h4) begin errors++; $display("FAIL first_pcplus4: got %h want 00000004", PCPlus4); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        logic [31:0] want;
        bit to;
        int bad;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            want = 32'(j * 4);
            serve(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), a, to, bad);
            checks++; if (to || a !== want) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", j, a, want); end
            checks++; if (bad !== 0) begin errors++; $display("FAIL seq_protocol[%0d]: got %0d want 0", j, bad); end
            checks++; if (instr_valid !== 1'b1 || Instr !== mem_word(want) || PC !== want) begin
                errors++; $display("FAIL seq_hold[%0d]: got v=%b i=%h pc=%h want v=1 i=%h pc=%h", j, instr_valid, Instr, PC, mem_word(want), want);
            end
            PCSrc = 1'b0;
            stall = 1'b0;
            step();
            checks++; if (instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1) begin
                errors++; $display("FAIL seq_consume[%0d]: got v=%b req=%b want v=0 req=1", j, instr_valid, imem_bus.imem_req);
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] a;
        bit to;
        int bad;
        do_reset();
        serve(0, 1, a, to, bad);
        PCSrc = 1'b1;
        PCTarget = 32'h0000_0100;
        step();
        PCSrc = 1'b0;
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_req: got req=%b addr=%h want req=1 addr=00000100", imem_bus.imem_req, imem_bus.imem_addr);
        end
        serve(1, 0, a, to, bad);
        checks++; if (to || a !== 32'h100 || bad !== 0) begin errors++; $display("FAIL redir_fetch: got addr=%h bad=%0d want addr=00000100 bad=0", a, bad); end
        checks++; if (PC !== 32'h100 || Instr !== mem_word(32'h100) || PCPlus4 !== 32'h104) begin
            errors++; $display("FAIL redir_hold: got pc=%h i=%h p4=%h want pc=00000100 i=%h p4=00000104", PC, Instr, PCPlus4, mem_word(32'h100));
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        bit to;
        int bad;
        int hold_bad;
        do_reset();
        serve(0, 0, a, to, bad);
        hold_bad = 0;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PCSrc = (i % 2 == 0);
            PCTarget = $urandom;
            imem_bus.imem_ready = 1'($urandom_range(0, 1));
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata = $urandom;
            step();
            if (Instr !== mem_word(32'h0) || PC !== 32'h0 || instr_valid !== 1'b1
                || imem_bus.imem_req !== 1'b0 || misaligned !== 1'b0) hold_bad++;
        end
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_bad); end
        stall = 1'b0;
        PCSrc = 1'b0;
        step();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4) begin
            errors++; $display("FAIL stall_release: got req=%b addr=%h want req=1 addr=00000004", imem_bus.imem_req, imem_bus.imem_addr);
        end
        serve(0, 0, a, to, bad);
        checks++; if (to || a !== 32'h4 || PC !== 32'h4 || bad !== 0) begin
            errors++; $display("FAIL stall_next: got addr=%h pc=%h bad=%0d want addr=00000004 pc=00000004 bad=0", a, PC, bad);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] a;
        bit to;
        int bad;
        int trap_bad;
        do_reset();
        serve(0, 0, a, to, bad);
        PCSrc = 1'b1;
        PCTarget = 32'h0000_0102;
        step();
        PCSrc = 1'b0;
        checks++; if (misaligned !== 1'b1 || imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL trap_entry: got mis=%b req=%b v=%b want mis=1 req=0 v=0", misaligned, imem_bus.imem_req, instr_valid);
        end
        trap_bad = 0;
        for (int i = 0; i < 8; i++) begin
            imem_bus.imem_ready = 1'($urandom_range(0, 1));
            imem_bus.imem_rvalid = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom;
            PCSrc = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            PCTarget = $urandom;
            step();
            if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b1) trap_bad++;
        end
        checks++; if (trap_bad !== 0) begin errors++; $display("FAIL trap_sticky: got %0d bad cycles want 0", trap_bad); end
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        PCSrc = 1'b0;
        stall = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (misaligned !== 1'b0 || imem_bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL trap_async_clear: got mis=%b req=%b want mis=0 req=0", misaligned, imem_bus.imem_req);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] a;
        bit to;
        int bad;
        do_reset();
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (imem_bus.imem_req === 1'b1) begin
                to = 1'b0;
                break;
            end
            step();
        end
        checks++; if (to) begin errors++; $display("FAIL midwait_timeout: no request seen, want imem_req=1"); end
        imem_bus.imem_ready = 1'b1;
        step();
        imem_bus.imem_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        imem_bus.imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RST_PC) begin
            errors++; $display("FAIL midwait_stale: got v=%b req=%b addr=%h want v=0 req=1 addr=%h", instr_valid, imem_bus.imem_req, imem_bus.imem_addr, RST_PC);
        end
        serve(0, 0, a, to, bad);
        checks++; if (to || a !== RST_PC || Instr !== mem_word(RST_PC) || bad !== 0) begin
            errors++; $display("FAIL midwait_refetch: got addr=%h i=%h want addr=%h i=%h", a, Instr, RST_PC, mem_word(RST_PC));
        end
        PCSrc = 1'b1;
        PCTarget = 32'hFFFF_FFFC;
        step();
        PCSrc = 1'b0;
        serve(0, 0, a, to, bad);
        checks++; if (to || a !== 32'hFFFF_FFFC || PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin
            errors++; $display("FAIL wrap_pcplus4: got addr=%h pc=%h p4=%h want addr=fffffffc pc=fffffffc p4=00000000", a, PC, PCPlus4);
        end
        step();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_fetch: got req=%b addr=%h want req=1 addr=00000000", imem_bus.imem_req, imem_bus.imem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        src;
        bit to;
        int bad;
        int hold_bad;
        int n_stall;
        do_reset();
        exp_pc = RST_PC;
        for (int t = 0; t < 30; t++) begin
            serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), a, to, bad);
            checks++; if (to || a !== exp_pc || bad !== 0) begin
                errors++; $display("FAIL rand_fetch[%0d]: got addr=%h bad=%0d to=%b want addr=%h bad=0", t, a, bad, to, exp_pc);
            end
            checks++; if (instr_valid !== 1'b1 || Instr !== mem_word(exp_pc) || PC !== exp_pc || PCPlus4 !== exp_pc + 32'd4) begin
                errors++; $display("FAIL rand_hold[%0d]: got v=%b i=%h pc=%h p4=%h want v=1 i=%h pc=%h p4=%h",
                                   t, instr_valid, Instr, PC, PCPlus4, mem_word(exp_pc), exp_pc, exp_pc + 32'd4);
            end
            hold_bad = 0;
            n_stall = int'($urandom_range(0, 3));
            stall = 1'b1;
            for (int s = 0; s < n_stall; s++) begin
                PCSrc = 1'($urandom_range(0, 1));
                PCTarget = $urandom;
                imem_bus.imem_rvalid = 1'($urandom_range(0, 1));
                imem_bus.imem_rdata = $urandom;
                step();
                if (instr_valid !== 1'b1 || Instr !== mem_word(exp_pc) || PC !== exp_pc || imem_bus.imem_req !== 1'b0) hold_bad++;
            end
            imem_bus.imem_rvalid = 1'b0;
            checks++; if (hold_bad !== 0) begin errors++; $display("FAIL rand_stall[%0d]: got %0d bad cycles want 0", t, hold_bad); end
            src = 1'($urandom_range(0, 1));
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            exp_pc = src ? tgt : exp_pc + 32'd4;
            stall = 1'b0;
            PCSrc = src;
            PCTarget = tgt;
            step();
            PCSrc = 1'b0;
            checks++; if (instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== exp_pc) begin
                errors++; $display("FAIL rand_consume[%0d]: got v=%b req=%b addr=%h want v=0 req=1 addr=%h",
                                   t, instr_valid, imem_bus.imem_req, imem_bus.imem_addr, exp_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_redirect();
        test_stall();
        test_misaligned();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
